distance_note_mapper: RTL

//   Parametrised successor to the inline distance->tuning-word mapping in the AirSynth top.

---
 rtl/distance_note_mapper.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/distance_note_mapper.sv
// Distance-to-note mapper: moving average, zone quantiser with hysteresis,
// writable note LUT, optional glide toward the note, and mute on sonar timeout.
module distance_note_mapper #(
  parameter int DIST_W     = 9,
  parameter int TW_W       = 32,
  parameter int NUM_ZONES  = 10,
  parameter int ZONE_SHIFT = 1,
  parameter int HYST       = 1,
  parameter int AVG_LOG2   = 2,
  parameter int GLIDE_DIV  = 1000,
  parameter int TIMEOUT    = 10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIST_W-1:0] distance_in,
  input  logic              valid_in,
  input  logic              glide_en,
  input  logic [TW_W-1:0]   glide_step,
  input  logic              lut_wr_en,
  input  logic [3:0]        lut_wr_addr,
  input  logic [TW_W-1:0]   lut_wr_data,
  output logic [TW_W-1:0]   tuning_word,
  output logic [3:0]        note_index,
  output logic              note_change,
  output logic              gate
);

  localparam int DEPTH = 2 ** AVG_LOG2;
  localparam int SUM_W = DIST_W + AVG_LOG2;
  localparam int CMP_W = DIST_W + ZONE_SHIFT + 6;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GD_W  = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;

  function automatic logic [TW_W-1:0] lut_default(input logic [3:0] idx);
    case (idx)
      4'd0:    lut_default = TW_W'(16'h15F2);
      4'd1:    lut_default = TW_W'(16'h18A2);
      4'd2:    lut_default = TW_W'(16'h1BA7);
      4'd3:    lut_default = TW_W'(16'h1D4B);
      4'd4:    lut_default = TW_W'(16'h20E2);
      4'd5:    lut_default = TW_W'(16'h24E9);
      4'd6:    lut_default = TW_W'(16'h296E);
      4'd7:    lut_default = TW_W'(16'h2BE5);
      4'd8:    lut_default = TW_W'(16'h3145);
      4'd9:    lut_default = TW_W'(16'h374D);
      default: lut_default = {TW_W{1'b0}};
    endcase
  endfunction

  logic [DIST_W-1:0] window [DEPTH];
  logic [SUM_W-1:0]  sum, new_sum;
  logic              empty, empty_eff;
  logic [DIST_W-1:0] avg;
  logic              avg_valid, avg_first;
  logic [TO_W-1:0]   to_cnt;
  logic              timeout_hit;
  logic [TW_W-1:0]   lut [16];
  logic [TW_W-1:0]   target;
  logic [GD_W-1:0]   div_cnt;
  logic              tick, gate_d;

  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT));
  assign empty_eff   = empty | timeout_hit;
  assign new_sum     = empty_eff ? (SUM_W'(distance_in) << AVG_LOG2)
                                 : sum - SUM_W'(window[DEPTH-1]) + SUM_W'(distance_in);

  // Sample window and running sum; an empty window is preloaded by one sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) window[i] <= {DIST_W{1'b0}};
      sum       <= {SUM_W{1'b0}};
      empty     <= 1'b1;
      avg       <= {DIST_W{1'b0}};
      avg_valid <= 1'b0;
      avg_first <= 1'b0;
    end else begin
      avg_valid <= valid_in;
      if (valid_in) begin
        window[0] <= distance_in;
        for (int i = 1; i < DEPTH; i++) window[i] <= empty_eff ? distance_in : window[i-1];
        sum       <= new_sum;
        empty     <= 1'b0;
        avg       <= DIST_W'(new_sum >> AVG_LOG2);
        avg_first <= empty_eff;
      end else if (timeout_hit) begin
        empty <= 1'b1;
      end else begin
        empty <= empty;
      end
    end
  end

  // Sonar watchdog: saturates at TIMEOUT, which holds the mute until the next sample.
  always_ff @(posedge clk) begin
    if (rst)                 to_cnt <= {TO_W{1'b0}};
    else if (valid_in)       to_cnt <= {TO_W{1'b0}};
    else if (!timeout_hit)   to_cnt <= to_cnt + TO_W'(1);
    else                     to_cnt <= to_cnt;
  end

  logic [DIST_W-1:0] raw_full;
  logic [3:0]        raw, next_zone;
  logic [CMP_W-1:0]  avg_c, lo, hi;
  logic              go_down, go_up;

  // Zone decision: leave the current zone only once avg clears its edge by HYST.
  always_comb begin
    raw_full = avg >> ZONE_SHIFT;
    if (raw_full > DIST_W'(NUM_ZONES - 1)) raw = 4'(NUM_ZONES - 1);
    else                                   raw = raw_full[3:0];
    avg_c     = CMP_W'(avg);
    lo        = CMP_W'(note_index) << ZONE_SHIFT;
    hi        = lo + CMP_W'(2 ** ZONE_SHIFT) + CMP_W'(HYST);
    go_down   = (note_index != 4'd0) && ((avg_c + CMP_W'(HYST)) < lo);
    go_up     = (note_index != 4'(NUM_ZONES - 1)) && (avg_c >= hi);
    if (avg_first || go_down || go_up) next_zone = raw;
    else                               next_zone = note_index;
  end

  // Zone register, change pulse and gate.
  always_ff @(posedge clk) begin
    if (rst) begin
      note_index  <= 4'd0;
      note_change <= 1'b0;
      gate        <= 1'b0;
    end else if (avg_valid) begin
      note_index  <= next_zone;
      note_change <= (next_zone != note_index);
      gate        <= 1'b1;
    end else begin
      note_change <= 1'b0;
      gate        <= gate & ~timeout_hit;
    end
  end

  // Note LUT; reset restores the C-major table and wins over a write.
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < 16; i++) lut[i] <= lut_default(4'(i));
    else if (lut_wr_en) lut[lut_wr_addr] <= lut_wr_data;
    else ;
  end

  assign target = lut[note_index];
  assign tick   = (div_cnt == GD_W'(GLIDE_DIV - 1));

  logic [TW_W:0]   up_sum, dn_diff, ext_t;
  logic [TW_W-1:0] glided, next_tw;

  // One clamped glide step toward target, and the next tuning word.
  always_comb begin
    ext_t   = {1'b0, target};
    up_sum  = {1'b0, tuning_word} + {1'b0, glide_step};
    dn_diff = {1'b0, tuning_word} - {1'b0, glide_step};
    if (tuning_word < target) begin
      glided = (up_sum > ext_t) ? target : up_sum[TW_W-1:0];
    end else if (tuning_word > target) begin
      glided = (dn_diff[TW_W] || (dn_diff < ext_t)) ? target : dn_diff[TW_W-1:0];
    end else begin
      glided = target;
    end
    // The first cycle after un-muting snaps, so a note never glides up from 0.
    if (!gate)                                                 next_tw = {TW_W{1'b0}};
    else if (!glide_en || (glide_step == {TW_W{1'b0}}) || !gate_d) next_tw = target;
    else if (tick)                                             next_tw = glided;
    else                                                       next_tw = tuning_word;
  end

  // Output register and free-running glide divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      tuning_word <= {TW_W{1'b0}};
      gate_d      <= 1'b0;
      div_cnt     <= {GD_W{1'b0}};
    end else begin
      tuning_word <= next_tw;
      gate_d      <= gate;
      div_cnt     <= tick ? {GD_W{1'b0}} : div_cnt + GD_W'(1);
    end
  end

endmodule
